// File: rtl/esn_pkg.sv
// esn_pkg: shared width helpers and FSM state encoding for the reservoir datapath blocks.
package esn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int prod_width(input int dw, input int ws);
        return dw + ws - 1;
    endfunction

    function automatic int acc_width(input int dw, input int ws, input int nt);
        return prod_width(dw, ws) + clog2(nt);
    endfunction

endpackage

// File: rtl/lane_saturate.sv
// lane_saturate: arithmetic right shift of one lane sum, then clip to a signed data_width value.
module lane_saturate #(
    parameter int acc_w      = 6,
    parameter int data_width = 3,
    parameter int shift      = 1
) (
    input  logic signed [acc_w-1:0]      sum,
    output logic        [data_width-1:0] value,
    output logic                         sat
);
    localparam logic signed [acc_w-1:0] hi = acc_w'((1 << (data_width - 1)) - 1);
    localparam logic signed [acc_w-1:0] lo = ~hi;

    logic signed [acc_w-1:0] r;

    assign r     = sum >>> shift;
    assign sat   = (r > hi) || (r < lo);
    assign value = r > hi ? hi[data_width-1:0] : r < lo ? lo[data_width-1:0] : r[data_width-1:0];
endmodule

// File: rtl/reservoir_accumulator.sv
// reservoir_accumulator: sums num_terms product beats per neuron, then shifts and saturates into a new state vector.
module reservoir_accumulator
    import esn_pkg::*;
#(
    parameter int data_width     = 3,
    parameter int weight_size    = 2,
    parameter int reservoir_size = 4,
    parameter int num_terms      = 4,
    parameter int shift          = 1,
    localparam int P  = prod_width(data_width, weight_size),
    localparam int A  = acc_width(data_width, weight_size, num_terms),
    localparam int CW = clog2(num_terms + 1)
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic                                 iValid,
    output logic                                 oReady,
    input  logic [P*reservoir_size-1:0]          iProducts,
    output logic                                 oValid,
    input  logic                                 iReady,
    output logic [data_width*reservoir_size-1:0] oData,
    output logic [reservoir_size-1:0]            oSat
);
    logic [1:0]              state, next_state;
    logic [CW-1:0]           count;
    logic signed [A-1:0]     acc [reservoir_size];
    logic [data_width-1:0]   sat_val [reservoir_size];
    logic [reservoir_size-1:0] sat_flag;
    logic                    take;

    assign take = iValid && oReady;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
            count <= '0;
            oData <= '0;
            oSat  <= '0;
            for (int k = 0; k < reservoir_size; k++) acc[k] <= '0;
        end else begin
            state <= next_state;
            if (take) begin
                count <= state == ST_IDLE ? CW'(1) : count + CW'(1);
                // The first beat of an update overwrites the accumulator, so no clear cycle is needed.
                for (int k = 0; k < reservoir_size; k++)
                    acc[k] <= (state == ST_IDLE ? '0 : acc[k]) + A'($signed(iProducts[k*P +: P]));
            end
            if (state == ST_SCALE) begin
                oSat <= sat_flag;
                for (int k = 0; k < reservoir_size; k++) oData[k*data_width +: data_width] <= sat_val[k];
            end
        end
    end

    always_comb begin
        next_state = state == ST_IDLE  ? (take ? (num_terms == 1 ? ST_SCALE : ST_ACCUM) : ST_IDLE)
                   : state == ST_ACCUM ? (take && count == CW'(num_terms - 1) ? ST_SCALE : ST_ACCUM)
                   : state == ST_SCALE ? ST_OUT
                   : (iReady ? ST_IDLE : ST_OUT);
    end

    always_comb begin
        oReady = state == ST_IDLE || state == ST_ACCUM;
        oValid = state == ST_OUT;
    end

    for (genvar g = 0; g < reservoir_size; g++) begin : g_lane
        lane_saturate #(
            .acc_w      (A),
            .data_width (data_width),
            .shift      (shift)
        ) u_sat (
            .sum   (acc[g]),
            .value (sat_val[g]),
            .sat   (sat_flag[g])
        );
    end
endmodule

// File: tb/tb_reservoir_accumulator.sv
// tb_reservoir_accumulator: directed vector table plus backpressure, gap and reset sequences at default parameters.
module tb_reservoir_accumulator;
    logic        iClk = 0;
    logic        iRst = 1;
    logic        iValid = 0;
    logic        oReady;
    logic [15:0] iProducts = '0;
    logic        oValid;
    logic        iReady = 0;
    logic [11:0] oData;
    logic [3:0]  oSat;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [3:0][15:0] beats;
        logic [11:0]      data;
        logic [3:0]       sat;
    } vec_t;

    vec_t vecs [5];

    reservoir_accumulator dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iProducts (iProducts),
        .oValid    (oValid),
        .iReady    (iReady),
        .oData     (oData),
        .oSat      (oSat)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic send_beats(input logic [3:0][15:0] beats, input int gap);
        for (int j = 0; j < 4; j++) begin
            if (j == 2) repeat (gap) tick();
            check("beat_ready", 32'(oReady), 1);
            iValid = 1;
            iProducts = beats[j];
            tick();
            iValid = 0;
        end
    endtask

    task automatic expect_result(input string name, input logic [11:0] d, input logic [3:0] s);
        check({name, "_scale_valid"}, 32'(oValid), 0);
        check({name, "_scale_ready"}, 32'(oReady), 0);
        tick();
        check({name, "_valid"}, 32'(oValid), 1);
        check({name, "_data"}, 32'(oData), 32'(d));
        check({name, "_sat"}, 32'(oSat), 32'(s));
    endtask

    task automatic handshake(input logic [11:0] d);
        iReady = 1;
        tick();
        iReady = 0;
        check("hs_valid_low", 32'(oValid), 0);
        check("hs_ready_high", 32'(oReady), 1);
        check("hs_data_kept", 32'(oData), 32'(d));
    endtask

    initial begin
        vecs[0] = '{beats: {16'h1111, 16'h1111, 16'h1111, 16'h1111}, data: 12'h492, sat: 4'b0000};
        vecs[1] = '{beats: {16'h0087, 16'h0087, 16'h0087, 16'h0087}, data: 12'h023, sat: 4'b0011};
        vecs[2] = '{beats: {16'h0000, 16'h0000, 16'h0000, 16'h1F00}, data: 12'h1C0, sat: 4'b0000};
        vecs[3] = '{beats: {16'h08E3, 16'h07E3, 16'h18E3, 16'h27E3}, data: 12'h3E3, sat: 4'b0001};
        vecs[4] = '{beats: {16'h0B5F, 16'h0B5F, 16'hFB5F, 16'h2B5F}, data: 12'h11E, sat: 4'b0110};

        tick();
        tick();
        iRst = 0;
        check("rst_valid", 32'(oValid), 0);
        check("rst_ready", 32'(oReady), 1);
        check("rst_data", 32'(oData), 0);
        check("rst_sat", 32'(oSat), 0);

        for (int i = 0; i < 5; i++) begin
            send_beats(vecs[i].beats, 0);
            expect_result($sformatf("vec%0d", i), vecs[i].data, vecs[i].sat);
            handshake(vecs[i].data);
        end

        // Backpressure: a pending beat must not be consumed while the result is held.
        send_beats(vecs[0].beats, 0);
        expect_result("bp", 12'h492, 4'b0000);
        iValid = 1;
        iProducts = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid", 32'(oValid), 1);
            check("bp_data", 32'(oData), 32'h492);
            check("bp_ready", 32'(oReady), 0);
        end
        iValid = 0;
        handshake(12'h492);
        send_beats(vecs[2].beats, 0);
        expect_result("after_bp", 12'h1C0, 4'b0000);
        handshake(12'h1C0);

        send_beats(vecs[0].beats, 3);
        expect_result("gap", 12'h492, 4'b0000);
        handshake(12'h492);

        // Reset after two +7 beats must discard the partial sum.
        send_beats(vecs[1].beats, 0);
        expect_result("pre_rst", 12'h023, 4'b0011);
        handshake(12'h023);
        for (int j = 0; j < 2; j++) begin
            iValid = 1;
            iProducts = 16'h7777;
            tick();
        end
        iValid = 0;
        iRst = 1;
        tick();
        iRst = 0;
        check("midrst_ready", 32'(oReady), 1);
        check("midrst_data", 32'(oData), 0);
        send_beats(vecs[0].beats, 0);
        expect_result("midrst", 12'h492, 4'b0000);

        iRst = 1;
        iReady = 0;
        tick();
        iRst = 0;
        check("outrst_valid", 32'(oValid), 0);
        check("outrst_ready", 32'(oReady), 1);
        check("outrst_sat", 32'(oSat), 0);
        send_beats(vecs[4].beats, 0);
        expect_result("post_rst", 12'h11E, 4'b0110);
        handshake(12'h11E);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
